// File: rtl/conv_out_collector_pkg.sv
// ----------------------------------------------------------------------------
// conv_out_collector_pkg
// Geometry and word-length constants shared by the BWN conv layer and the
// output collector, so both ends of the stream always agree on frame shape.
//   IWL/OWL  : conv output word length / activated output word length
//   IMG_W/H  : input image size (IMG_W is also the conv line-buffer length)
//   LAT      : cycles from conv pixel accept to its window sum on the bus
//   N_OUT    : number of valid 3x3 windows per frame
//   AW       : feature-map write-address width (2**AW >= N_OUT)
// ----------------------------------------------------------------------------
package conv_out_collector_pkg;

    localparam int IWL   = 16;
    localparam int OWL   = 8;
    localparam int IMG_W = 17;
    localparam int IMG_H = 17;
    localparam int LAT   = 2;
    localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int AW    = 9;

    // Column / row counter widths.
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/conv_out_collector_if.sv
// ----------------------------------------------------------------------------
// conv_out_collector_if
// Stream-in / RAM-write-out bundle of the collector.
//   iSTART   : stream-active qualifier (same net as the conv layer's)
//   iDATA    : conv layer window sum, signed IWL
//   oWR_EN   : feature-map RAM write strobe
//   oWR_ADDR : raster-order write address
//   oWR_DATA : activated, saturated result, signed OWL
//   oBUSY    : frame in progress
//   oDONE    : one-cycle pulse on the last write of a frame
// Modports: slave = collector side, master = stream source / RAM observer.
// ----------------------------------------------------------------------------
interface conv_out_collector_if;
    import conv_out_collector_pkg::*;

    logic                  iSTART;
    logic signed [IWL-1:0] iDATA;
    logic                  oWR_EN;
    logic [AW-1:0]         oWR_ADDR;
    logic signed [OWL-1:0] oWR_DATA;
    logic                  oBUSY;
    logic                  oDONE;

    modport slave (
        input  iSTART, iDATA,
        output oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE
    );

    modport master (
        output iSTART, iDATA,
        input  oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE
    );

endinterface

// File: rtl/conv_out_collector_sat_relu.sv
// ----------------------------------------------------------------------------
// conv_out_collector_sat_relu
// Combinational activation: optional ReLU followed by signed saturation from
// IW bits down to OW bits. No fractional shift. Reusable at the pooling stage.
//   din  : signed IW-bit input
//   dout : signed OW-bit output, clamped to [-(2**(OW-1)), 2**(OW-1)-1]
// ----------------------------------------------------------------------------
module conv_out_collector_sat_relu #(
    parameter int IW   = 16,
    parameter int OW   = 8,
    parameter bit RELU = 1'b1
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam logic signed [IW-1:0] MAXV = IW'((2 ** (OW - 1)) - 1);
    localparam logic signed [IW-1:0] MINV = IW'(-(2 ** (OW - 1)));

    logic signed [IW-1:0] relu_v;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        relu_v = din;
        dout   = '0;
        if (RELU && din[IW-1]) begin
            relu_v = '0;
        end
        if (relu_v > MAXV) begin
            dout = MAXV[OW-1:0];
        end else if (relu_v < MINV) begin
            dout = MINV[OW-1:0];
        end else begin
            dout = relu_v[OW-1:0];
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// ----------------------------------------------------------------------------
// conv_out_collector
// Sink end of the BWN 3x3 convolution stream. Tracks the image position of
// the window sum currently on iDATA, drops pipeline-fill and row-wrap windows
// (row < 2 or col < 2), activates/saturates the rest and writes them in raster
// order to the next layer's feature-map RAM. oDONE pulses with the last write.
//   iCLK : clock
//   iRST : synchronous reset, active-high
//   bus  : slave modport (iSTART/iDATA in, RAM write and status out)
// Parameter RELU selects ReLU before saturation.
// ----------------------------------------------------------------------------
module conv_out_collector
    import conv_out_collector_pkg::*;
#(
    parameter bit RELU = 1'b1
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    conv_out_collector_if.slave  bus
);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);

    logic [LAT-1:0]        vld_pipe;
    logic                  vld_d;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [AW-1:0]         wcnt;
    logic                  wr_hit;
    logic                  last_hit;
    logic signed [OWL-1:0] act_data;
    state_e                state, state_nxt;

    // The pipe shifts every cycle (not only on accepts) so that after a pause
    // its tap still lines up with the window sum the conv layer emits.
    assign vld_d    = vld_pipe[LAT-1];
    assign wr_hit   = vld_d && (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign last_hit = wr_hit && (row == ROW_LAST) && (col == COL_LAST);

    conv_out_collector_sat_relu #(
        .IW   (IWL),
        .OW   (OWL),
        .RELU (RELU)
    ) u_sat_relu (
        .din  (bus.iDATA),
        .dout (act_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.iSTART) state_nxt = ST_RUN;
            ST_RUN:  if (last_hit)   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here makes results order-dependent.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= ST_IDLE;
            vld_pipe     <= '0;
            col          <= '0;
            row          <= '0;
            wcnt         <= '0;
            bus.oWR_EN   <= 1'b0;
            bus.oWR_ADDR <= '0;
            bus.oWR_DATA <= '0;
            bus.oBUSY    <= 1'b0;
            bus.oDONE    <= 1'b0;
        end else begin
            state       <= state_nxt;
            vld_pipe[0] <= bus.iSTART;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end

            // Position of the window on iDATA; the wrap at the bottom-right
            // corner is what restarts the next frame at (0,0).
            if (vld_d) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            bus.oWR_EN <= wr_hit;
            if (wr_hit) begin
                bus.oWR_ADDR <= wcnt;
                bus.oWR_DATA <= act_data;
                wcnt         <= last_hit ? '0 : wcnt + 1'b1;
            end

            bus.oBUSY <= (state_nxt != ST_IDLE);
            bus.oDONE <= (state == ST_RUN) && last_hit;
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
// ----------------------------------------------------------------------------
// tb_conv_out_collector
// Drives two collectors (RELU=1 and RELU=0) from one stream. The bench plays
// the conv layer: random images and random +/-1 3x3 weights per frame, each
// accepted pixel's window sum presented LAT cycles later. The expected RAM
// writes come from image coordinates of each accepted pixel.
// ----------------------------------------------------------------------------
module tb_conv_out_collector;
    import conv_out_collector_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    logic                  iclk = 1'b0;
    logic                  irst;
    logic                  drv_start;
    logic signed [IWL-1:0] drv_data;

    conv_out_collector_if bus_relu ();
    conv_out_collector_if bus_lin ();

    assign bus_relu.iSTART = drv_start;
    assign bus_relu.iDATA  = drv_data;
    assign bus_lin.iSTART  = drv_start;
    assign bus_lin.iDATA   = drv_data;

    conv_out_collector #(.RELU(1'b1)) u_dut_relu (
        .iCLK (iclk),
        .iRST (irst),
        .bus  (bus_relu)
    );

    conv_out_collector #(.RELU(1'b0)) u_dut_lin (
        .iCLK (iclk),
        .iRST (irst),
        .bus  (bus_lin)
    );

    always #5 iclk = ~iclk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: pixel index / frame slot of recent accepts (-1 = none).
    int pipe_k [LAT];
    int pipe_s [LAT];
    int acc_k;
    int fid;
    int img [2][IMG_H][IMG_W];
    int wts [2][9];
    int forced [$];
    int exp_addr, exp_d_relu, exp_d_lin;
    bit exp_busy, prev_done;

    // Observations of the RELU=1 instance.
    int dut_wr_cnt;
    int dut_first_e;
    int dut_done_e [$];
    int start_a;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int act(input int v, input bit relu);
        int t;
        int hi;
        int lo;
        hi = (1 << (OWL - 1)) - 1;
        lo = -(1 << (OWL - 1));
        t  = (relu && v < 0) ? 0 : v;
        if (t > hi)      t = hi;
        else if (t < lo) t = lo;
        return t;
    endfunction

    task automatic new_frame(input int slot);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[slot][r][c] = int'($urandom_range(120)) - 60;
        for (int i = 0; i < 9; i++)
            wts[slot][i] = ($urandom_range(1) == 1) ? 1 : -1;
    endtask

    function automatic int window(input int slot, input int r, input int c);
        int sum;
        sum = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum += wts[slot][i*3+j] * img[slot][r-2+i][c-2+j];
        return sum;
    endfunction

    // One clock edge: drive iSTART/iDATA (and iRST), then check both DUTs.
    task automatic step(input bit st, input bit rst);
        int  k, s, r, c, v, e;
        bit  wr, dn;
        k  = pipe_k[LAT-1];
        s  = pipe_s[LAT-1];
        wr = 1'b0;
        dn = 1'b0;
        r  = 0;
        c  = 0;
        v  = int'($urandom_range(1600)) - 800;   // fill / wrap garbage
        if (!rst && k >= 0) begin
            r = k / IMG_W;
            c = k % IMG_W;
            if (r >= 2 && c >= 2) begin
                wr = 1'b1;
                dn = (k == NPIX - 1);
                if (forced.size() > 0) v = forced.pop_front();
                else                   v = window(s, r, c);
            end
        end
        irst      = rst;
        drv_start = st;
        drv_data  = IWL'(v);

        if (rst) begin
            foreach (pipe_k[i]) pipe_k[i] = -1;
            acc_k = 0;
            fid++;
            new_frame(fid % 2);
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_k[i] = pipe_k[i-1];
                pipe_s[i] = pipe_s[i-1];
            end
            pipe_k[0] = st ? acc_k : -1;
            pipe_s[0] = fid % 2;
            if (st) begin
                acc_k++;
                if (acc_k == NPIX) begin
                    acc_k = 0;
                    fid++;
                    new_frame(fid % 2);
                end
            end
        end

        e = cyc;
        @(posedge iclk);
        #1;
        cyc++;

        if (rst) begin
            exp_addr   = 0;
            exp_d_relu = 0;
            exp_d_lin  = 0;
            exp_busy   = 1'b0;
            prev_done  = 1'b0;
            dut_wr_cnt = 0;
        end else begin
            if (wr) begin
                exp_addr   = (r - 2) * (IMG_W - 2) + (c - 2);
                exp_d_relu = act(v, 1'b1);
                exp_d_lin  = act(v, 1'b0);
            end
            if (dn)             exp_busy = 1'b1;
            else if (prev_done) exp_busy = 1'b0;
            else if (st)        exp_busy = 1'b1;
            prev_done = dn;
        end

        check("wr_en_relu",   32'(bus_relu.oWR_EN),   32'(wr));
        check("wr_en_lin",    32'(bus_lin.oWR_EN),    32'(wr));
        check("wr_addr_relu", 32'(bus_relu.oWR_ADDR), exp_addr);
        check("wr_addr_lin",  32'(bus_lin.oWR_ADDR),  exp_addr);
        check("wr_data_relu", 32'(bus_relu.oWR_DATA), exp_d_relu);
        check("wr_data_lin",  32'(bus_lin.oWR_DATA),  exp_d_lin);
        check("done_relu",    32'(bus_relu.oDONE),    32'(dn));
        check("done_lin",     32'(bus_lin.oDONE),     32'(dn));
        check("busy_relu",    32'(bus_relu.oBUSY),    32'(exp_busy));

        if (!rst) begin
            if (bus_relu.oWR_EN) begin
                dut_wr_cnt++;
                if (dut_first_e < 0) dut_first_e = e;
            end
            if (bus_relu.oDONE) begin
                dut_done_e.push_back(e);
                check("frame_writes", dut_wr_cnt, N_OUT);
                check("done_addr", 32'(bus_relu.oWR_ADDR), N_OUT - 1);
                check("done_with_wr_en", 32'(bus_relu.oWR_EN), 1);
                dut_wr_cnt = 0;
            end
        end
    endtask

    initial begin
        foreach (pipe_k[i]) begin
            pipe_k[i] = -1;
            pipe_s[i] = 0;
        end
        acc_k       = 0;
        fid         = 0;
        exp_addr    = 0;
        exp_d_relu  = 0;
        exp_d_lin   = 0;
        exp_busy    = 1'b0;
        prev_done   = 1'b0;
        dut_wr_cnt  = 0;
        dut_first_e = -1;
        irst        = 1'b1;
        drv_start   = 1'b0;
        drv_data    = '0;
        new_frame(0);

        // Reset: every output must read 0.
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Frame A, continuous: first windows carry saturation corner values.
        forced = '{300, -5, 100, -300, -5, 127, 128, -128, -129};
        start_a     = cyc;
        dut_first_e = -1;
        repeat (NPIX) step(1'b1, 1'b0);
        repeat (LAT) step(1'b1, 1'b0);   // frame B begins back-to-back
        check("first_wr_edge", dut_first_e - start_a, 38);
        check("done_count_a", dut_done_e.size(), 1);
        if (dut_done_e.size() >= 1)
            check("last_wr_edge", dut_done_e[0] - start_a, 290);

        // Rest of frame B.
        repeat (NPIX - LAT) step(1'b1, 1'b0);

        // Frame C, back-to-back, with a 10-cycle iSTART gap mid row 5.
        repeat (5 * IMG_W + 8) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (NPIX - (5 * IMG_W + 8)) step(1'b1, 1'b0);

        // Frame D aborted by reset at pixel 150.
        repeat (150) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("done_count_before_e", dut_done_e.size(), 3);

        // Frame E after reset, then drain.
        repeat (NPIX) step(1'b1, 1'b0);
        repeat (LAT + 2) step(1'b0, 1'b0);

        check("done_count_total", dut_done_e.size(), 4);
        if (dut_done_e.size() >= 3) begin
            check("done_gap_ab", dut_done_e[1] - dut_done_e[0], NPIX);
            check("done_gap_bc", dut_done_e[2] - dut_done_e[1], NPIX + 10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
